// File: rtl/ccm_ctr_gen.sv
// rtl/ccm_ctr_gen.sv - CCM counter-block generator feeding the AES core
// Issues A_1..A_n on data-buffer requests, then A_0 tagged for MAC encryption.
module ccm_ctr_gen #(
  parameter int WIDTH_NONCE = 100,
  parameter int WIDTH_FLAG  = 8,
  parameter int WIDTH_COUNT = 20,
  localparam int WIDTH_KEY  = WIDTH_NONCE + WIDTH_FLAG + WIDTH_COUNT
) (
  input  logic                   clk,
  input  logic                   kill_n,
  input  logic                   start,
  input  logic [WIDTH_NONCE-1:0] nonce,
  input  logic [WIDTH_FLAG-1:0]  flag,
  input  logic                   block_req,
  input  logic                   last_block,
  input  logic                   aes_ready,
  input  logic                   aes_done,
  output logic [WIDTH_KEY-1:0]   aes_data,
  output logic                   aes_en,
  output logic                   s0_sel,
  output logic                   busy,
  output logic                   ctr_done,
  output logic                   ctr_err
);

  typedef enum logic [2:0] {
    IDLE, WAIT_REQ, ISSUE, WAIT_AES, TAG_ISSUE, TAG_WAIT
  } state_t;

  state_t                 state;
  logic [WIDTH_NONCE-1:0] nonce_r;
  logic [WIDTH_FLAG-1:0]  flag_r;
  logic [WIDTH_COUNT-1:0] count_r;
  logic                   req_pend;
  logic                   req_last;
  logic                   last_pend;

  always_ff @(posedge clk) begin
    if (!kill_n) begin
      state     <= IDLE;
      nonce_r   <= '0;
      flag_r    <= '0;
      count_r   <= '0;
      req_pend  <= 1'b0;
      req_last  <= 1'b0;
      last_pend <= 1'b0;
      aes_data  <= '0;
      aes_en    <= 1'b0;
      s0_sel    <= 1'b0;
      busy      <= 1'b0;
      ctr_done  <= 1'b0;
      ctr_err   <= 1'b0;
    end else begin
      aes_en   <= 1'b0;
      ctr_done <= 1'b0;

      // A block in flight can hold one queued request; anything beyond that,
      // or any request once the final block is known, is an overrun.
      if ((state == ISSUE || state == WAIT_AES) && block_req) begin
        if (req_pend || last_pend) begin
          ctr_err <= 1'b1;
        end else begin
          req_pend <= 1'b1;
          req_last <= last_block;
        end
      end
      if ((state == TAG_ISSUE || state == TAG_WAIT) && block_req) begin
        ctr_err <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (start) begin
            nonce_r   <= nonce;
            flag_r    <= flag;
            count_r   <= {{(WIDTH_COUNT-1){1'b0}}, 1'b1};
            busy      <= 1'b1;
            ctr_err   <= 1'b0;
            req_pend  <= 1'b0;
            last_pend <= 1'b0;
            state     <= WAIT_REQ;
          end
        end
        WAIT_REQ: begin
          if (block_req || req_pend) begin
            aes_data  <= {flag_r, nonce_r, count_r};
            last_pend <= req_pend ? req_last : last_block;
            req_pend  <= req_pend && block_req;
            req_last  <= last_block;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          if (aes_ready) begin
            aes_en <= 1'b1;
            state  <= WAIT_AES;
          end
        end
        WAIT_AES: begin
          if (aes_done) begin
            if (last_pend) begin
              aes_data <= {flag_r, nonce_r, {WIDTH_COUNT{1'b0}}};
              state    <= TAG_ISSUE;
            end else begin
              // Wrapping is reported but the message keeps running.
              if (&count_r) begin
                ctr_err <= 1'b1;
              end
              count_r <= count_r + 1'b1;
              state   <= WAIT_REQ;
            end
          end
        end
        TAG_ISSUE: begin
          if (aes_ready) begin
            aes_en <= 1'b1;
            s0_sel <= 1'b1;
            state  <= TAG_WAIT;
          end
        end
        TAG_WAIT: begin
          if (aes_done) begin
            ctr_done  <= 1'b1;
            busy      <= 1'b0;
            s0_sel    <= 1'b0;
            last_pend <= 1'b0;
            req_pend  <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ccm_ctr_gen.sv
// tb/tb_ccm_ctr_gen.sv - self-checking bench for ccm_ctr_gen
// Expected counter blocks are queued at stimulus time and popped on each aes_en.
module tb_ccm_ctr_gen;

  logic         clk = 1'b0;
  logic         kill_n = 1'b0;
  logic         start = 1'b0;
  logic [99:0]  nonce = '0;
  logic [7:0]   flag = '0;
  logic         block_req = 1'b0;
  logic         last_block = 1'b0;
  logic         aes_ready = 1'b1;
  logic         aes_done = 1'b0;
  logic [127:0] aes_data;
  logic         aes_en;
  logic         s0_sel;
  logic         busy;
  logic         ctr_done;
  logic         ctr_err;

  int tests = 0;
  int fails = 0;
  int en_cnt = 0;
  int done_cnt = 0;
  logic [127:0] exp_q[$];
  logic         exp_s0_q[$];

  logic [99:0] cur_nonce;
  logic [7:0]  cur_flag;

  ccm_ctr_gen dut (
    .clk(clk), .kill_n(kill_n), .start(start), .nonce(nonce), .flag(flag),
    .block_req(block_req), .last_block(last_block), .aes_ready(aes_ready),
    .aes_done(aes_done), .aes_data(aes_data), .aes_en(aes_en), .s0_sel(s0_sel),
    .busy(busy), .ctr_done(ctr_done), .ctr_err(ctr_err)
  );

  always #5 clk = ~clk;

  // Scoreboard: every issued block must match the oldest expectation.
  always @(negedge clk) begin
    if (kill_n && aes_en) begin
      en_cnt++;
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_aes_en got data=%h s0=%b, expected no issue", aes_data, s0_sel);
      end else begin
        logic [127:0] e;
        logic         es0;
        e   = exp_q.pop_front();
        es0 = exp_s0_q.pop_front();
        if ({s0_sel, aes_data} !== {es0, e}) begin
          fails++;
          $display("FAIL issue_block got s0=%b data=%h, expected s0=%b data=%h", s0_sel, aes_data, es0, e);
        end
      end
    end
    if (kill_n && ctr_done) done_cnt++;
  end

  function automatic logic [127:0] blk(input logic [19:0] cnt);
    return {cur_flag, cur_nonce, cnt};
  endfunction

  task automatic expect_blk(input logic [19:0] cnt, input logic s0);
    exp_q.push_back(blk(cnt));
    exp_s0_q.push_back(s0);
  endtask

  task automatic do_start(input logic [7:0] f, input logic [99:0] n);
    cur_flag  = f;
    cur_nonce = n;
    @(negedge clk);
    start = 1'b1; flag = f; nonce = n;
    @(negedge clk);
    start = 1'b0; flag = '0; nonce = '0;
  endtask

  task automatic send_req(input logic last);
    @(negedge clk);
    block_req = 1'b1; last_block = last;
    @(negedge clk);
    block_req = 1'b0; last_block = 1'b0;
  endtask

  task automatic pulse_done();
    @(negedge clk);
    aes_done = 1'b1;
    @(negedge clk);
    aes_done = 1'b0;
  endtask

  task automatic wait_en(output bit got);
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (aes_en) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    bit got;
    kill_n = 1'b0;
    repeat (3) @(negedge clk);
    tests++;
    if ({aes_data, aes_en, s0_sel, busy, ctr_done, ctr_err} !== '0) begin
      fails++;
      $display("FAIL reset_outputs got data=%h en=%b s0=%b busy=%b done=%b err=%b, expected all 0",
               aes_data, aes_en, s0_sel, busy, ctr_done, ctr_err);
    end
    kill_n = 1'b1;
    send_req(1'b1);
    pulse_done();
    wait_en(got);
    tests++;
    if (got || busy !== 1'b0) begin
      fails++;
      $display("FAIL idle_ignores_req got en=%b busy=%b, expected en=0 busy=0", got, busy);
    end
  endtask

  task automatic test_single();
    bit got;
    do_start(8'h5A, 100'h0123456789ABCDEF012345678);
    tests++;
    if (busy !== 1'b1) begin
      fails++;
      $display("FAIL start_busy got %b, expected 1", busy);
    end
    expect_blk(20'h00001, 1'b0);
    send_req(1'b1);
    tests++;
    if (aes_en !== 1'b0) begin
      fails++;
      $display("FAIL latency_early got aes_en=%b, expected 0", aes_en);
    end
    @(negedge clk);
    tests++;
    if (aes_en !== 1'b1) begin
      fails++;
      $display("FAIL latency_t2 got aes_en=%b, expected 1", aes_en);
    end
    expect_blk(20'h00000, 1'b1);
    pulse_done();
    wait_en(got);
    tests++;
    if (!got) begin
      fails++;
      $display("FAIL tag_issue_timeout got no aes_en, expected tag block");
    end
    repeat (2) @(negedge clk);
    tests++;
    if (s0_sel !== 1'b1) begin
      fails++;
      $display("FAIL s0_sel_hold got %b, expected 1", s0_sel);
    end
    pulse_done();
    tests++;
    if ({ctr_done, busy, s0_sel} !== 3'b100) begin
      fails++;
      $display("FAIL single_finish got done=%b busy=%b s0=%b, expected 1 0 0", ctr_done, busy, s0_sel);
    end
    @(negedge clk);
    tests++;
    if (ctr_done !== 1'b0) begin
      fails++;
      $display("FAIL ctr_done_pulse got %b, expected 0", ctr_done);
    end
  endtask

  task automatic test_three_block();
    bit got;
    int en0;
    en0 = en_cnt;
    do_start(8'hA5, 100'hFEDCBA9876543210FEDCBA987);
    for (int i = 1; i <= 3; i++) begin
      expect_blk(20'(i), 1'b0);
      send_req(i == 3);
      wait_en(got);
      tests++;
      if (!got) begin
        fails++;
        $display("FAIL three_issue_timeout block=%0d got no aes_en, expected issue", i);
      end
      if (i == 3) expect_blk(20'h0, 1'b1);
      pulse_done();
    end
    wait_en(got);
    pulse_done();
    tests++;
    if ({ctr_done, busy, ctr_err} !== 3'b100 || en_cnt - en0 != 4) begin
      fails++;
      $display("FAIL three_finish got done=%b busy=%b err=%b pulses=%0d, expected 1 0 0 pulses=4",
               ctr_done, busy, ctr_err, en_cnt - en0);
    end
  endtask

  task automatic test_stall_and_pending();
    bit got;
    do_start(8'h3C, 100'h00000000000000000000ABCDE);
    aes_ready = 1'b0;
    expect_blk(20'h1, 1'b0);
    send_req(1'b0);
    for (int i = 0; i < 5; i++) begin
      tests++;
      if (aes_en !== 1'b0 || aes_data !== blk(20'h1)) begin
        fails++;
        $display("FAIL stall_hold cyc=%0d got en=%b data=%h, expected en=0 data=%h", i, aes_en, aes_data, blk(20'h1));
      end
      if (i < 4) @(negedge clk);
    end
    aes_ready = 1'b1;
    @(negedge clk);
    tests++;
    if (aes_en !== 1'b1) begin
      fails++;
      $display("FAIL stall_release got aes_en=%b, expected 1", aes_en);
    end
    @(negedge clk);
    tests++;
    if (aes_en !== 1'b0) begin
      fails++;
      $display("FAIL stall_single_pulse got aes_en=%b, expected 0", aes_en);
    end
    expect_blk(20'h2, 1'b0);
    send_req(1'b0);
    pulse_done();
    wait_en(got);
    tests++;
    if (!got) begin
      fails++;
      $display("FAIL pending_issue_timeout got no aes_en, expected count 2");
    end
    send_req(1'b1);
    tests++;
    if (ctr_err !== 1'b0) begin
      fails++;
      $display("FAIL pending_no_err got ctr_err=%b, expected 0", ctr_err);
    end
    send_req(1'b0);
    tests++;
    if (ctr_err !== 1'b1) begin
      fails++;
      $display("FAIL overrun_err got ctr_err=%b, expected 1", ctr_err);
    end
    expect_blk(20'h3, 1'b0);
    pulse_done();
    wait_en(got);
    expect_blk(20'h0, 1'b1);
    pulse_done();
    wait_en(got);
    pulse_done();
    tests++;
    if ({ctr_done, ctr_err} !== 2'b11) begin
      fails++;
      $display("FAIL pending_finish got done=%b err=%b, expected 1 1", ctr_done, ctr_err);
    end
  endtask

  task automatic test_back_to_back();
    bit got;
    do_start(8'h11, 100'h123);
    tests++;
    if (ctr_err !== 1'b0) begin
      fails++;
      $display("FAIL start_clears_err got %b, expected 0", ctr_err);
    end
    expect_blk(20'h1, 1'b0);
    send_req(1'b0);
    wait_en(got);
    expect_blk(20'h2, 1'b0);
    @(negedge clk);
    aes_done = 1'b1; block_req = 1'b1; last_block = 1'b1;
    @(negedge clk);
    aes_done = 1'b0; block_req = 1'b0; last_block = 1'b0;
    wait_en(got);
    tests++;
    if (!got) begin
      fails++;
      $display("FAIL simul_done_req got no aes_en, expected count 2");
    end
    expect_blk(20'h0, 1'b1);
    pulse_done();
    wait_en(got);
    pulse_done();
    tests++;
    if ({ctr_done, ctr_err} !== 2'b10) begin
      fails++;
      $display("FAIL b2b_finish got done=%b err=%b, expected 1 0", ctr_done, ctr_err);
    end
  endtask

  task automatic test_overflow();
    bit got;
    do_start(8'h77, 100'hCAFE);
    @(negedge clk);
    force dut.count_r = 20'hFFFFF;
    @(negedge clk);
    release dut.count_r;
    expect_blk(20'hFFFFF, 1'b0);
    send_req(1'b0);
    wait_en(got);
    tests++;
    if (!got || ctr_err !== 1'b0) begin
      fails++;
      $display("FAIL max_count_issue got en=%b err=%b, expected en=1 err=0", got, ctr_err);
    end
    pulse_done();
    tests++;
    if (ctr_err !== 1'b1) begin
      fails++;
      $display("FAIL overflow_err got ctr_err=%b, expected 1", ctr_err);
    end
    expect_blk(20'h0, 1'b0);
    send_req(1'b1);
    wait_en(got);
    expect_blk(20'h0, 1'b1);
    pulse_done();
    wait_en(got);
    pulse_done();
  endtask

  task automatic test_kill();
    bit got;
    int en0;
    int d0;
    do_start(8'h99, 100'hBEEF);
    expect_blk(20'h1, 1'b0);
    send_req(1'b0);
    wait_en(got);
    @(negedge clk);
    kill_n = 1'b0;
    @(negedge clk);
    kill_n = 1'b1;
    en0 = en_cnt;
    d0  = done_cnt;
    pulse_done();
    repeat (5) @(negedge clk);
    tests++;
    if (en_cnt != en0 || done_cnt != d0 ||
        {aes_data, aes_en, s0_sel, busy, ctr_done, ctr_err} !== '0) begin
      fails++;
      $display("FAIL kill_abandon got en+%0d done+%0d data=%h busy=%b err=%b, expected no activity and zero outputs",
               en_cnt - en0, done_cnt - d0, aes_data, busy, ctr_err);
    end
    do_start(8'h42, 100'h5555);
    expect_blk(20'h1, 1'b0);
    send_req(1'b1);
    wait_en(got);
    tests++;
    if (!got) begin
      fails++;
      $display("FAIL restart_issue got no aes_en, expected count 1");
    end
    expect_blk(20'h0, 1'b1);
    pulse_done();
    wait_en(got);
    pulse_done();
    @(negedge clk);
    tests++;
    if (exp_q.size() != 0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL scoreboard_drain got %0d pending busy=%b, expected 0 pending busy=0", exp_q.size(), busy);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_three_block();
    test_stall_and_pending();
    test_back_to_back();
    test_overflow();
    test_kill();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
